// File: rtl/io_reg_bank_pkg.sv
// Shared definitions for the memory-mapped I/O register banks (PPU, sound, timer).
package io_pkg;

   localparam int unsigned ADDR_W   = 16;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned MAX_REGS = 64;
   localparam int unsigned SLICE_W  = MAX_REGS * DATA_W;

   typedef logic [DATA_W-1:0] io_byte_t;

   localparam logic [ADDR_W-1:0] PPU_BASE = 16'hff40;
   localparam logic [ADDR_W-1:0] SND_BASE = 16'hff10;
   localparam logic [ADDR_W-1:0] TIM_BASE = 16'hff04;

   // Byte i of a packed register vector; callers zero-extend their vector to SLICE_W.
   function automatic io_byte_t io_slice(input logic [SLICE_W-1:0] vec, input int unsigned i);
      return DATA_W'(vec >> (DATA_W * i));
   endfunction

endpackage

// File: rtl/io_reg_bank_if.sv
// CPU-side register bus: address, write data, level read/write requests, registered read return.
interface io_bus_if;
   import io_pkg::*;

   logic [ADDR_W-1:0] a;
   io_byte_t          d_in;
   logic              wr;
   logic              rd;
   io_byte_t          rd_data;
   logic              rd_valid;

   modport master (
      output a, d_in, wr, rd,
      input  rd_data, rd_valid
   );

   modport slave (
      input  a, d_in, wr, rd,
      output rd_data, rd_valid
   );

endinterface

// File: rtl/io_reg_bank_window_decode.sv
// Combinational decode of a contiguous NREGS-byte window at BASE into one-hot select, hit and index.
module io_window_decode
   import io_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE   = PPU_BASE,
   parameter int unsigned       NREGS  = 12,
   localparam int unsigned      IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic [ADDR_W-1:0] a,
   output logic [NREGS-1:0]  sel,
   output logic              hit,
   output logic [IDX_W-1:0]  idx
);

   // Full 16-bit compare per register, so an unaligned BASE needs no special handling.
   always_comb begin
      sel = '0;
      idx = '0;
      for (int i = 0; i < int'(NREGS); i++) begin
         sel[i] = (a == ADDR_W'(BASE + ADDR_W'(i)));
         if (sel[i]) begin
            idx = idx | IDX_W'(i);
         end
      end
      hit = |sel;
   end

endmodule

// File: rtl/io_reg_bank.sv
// Parametrised I/O register bank: window decode, write-edge strobes, stored
// writable registers and a one-cycle registered read port.
module io_reg_bank
   import io_pkg::*;
#(
   parameter logic [ADDR_W-1:0]        BASE      = PPU_BASE,
   parameter int unsigned              NREGS     = 12,
   parameter logic [NREGS-1:0]         RW_MASK   = {NREGS{1'b1}},
   parameter logic [NREGS*DATA_W-1:0]  RESET_VAL = '0,
   localparam int unsigned             IDX_W     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic                      clk,
   input  logic                      nreset,
   io_bus_if.slave                   bus,
   output logic [NREGS-1:0]          sel,
   output logic                      hit,
   output logic [NREGS-1:0]          wr_pulse,
   output logic [NREGS*DATA_W-1:0]   regs,
   input  logic [NREGS*DATA_W-1:0]   ext_in
);

   if (NREGS < 1 || NREGS > MAX_REGS) begin : g_bad_nregs
      $error("io_reg_bank: NREGS=%0d outside 1..%0d", NREGS, MAX_REGS);
   end
   if ((32'(BASE) + 32'(NREGS) - 32'd1) > 32'h0000_ffff) begin : g_bad_window
      $error("io_reg_bank: window at BASE=%h with NREGS=%0d exceeds 16'hffff", BASE, NREGS);
   end

   function automatic logic [NREGS*DATA_W-1:0] expand_mask(input logic [NREGS-1:0] m);
      logic [NREGS*DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < int'(NREGS); i++) begin
         r[DATA_W*i +: DATA_W] = {DATA_W{m[i]}};
      end
      return r;
   endfunction

   // Read-only slices are forced to zero so they reset and hold as constants.
   localparam logic [NREGS*DATA_W-1:0] RW_BITS = expand_mask(RW_MASK);

   logic              wr_q;
   logic              wr_edge;
   logic              mask_hit;
   logic [IDX_W-1:0]  idx;
   io_byte_t          rd_byte;

   io_window_decode #(
      .BASE  (BASE),
      .NREGS (NREGS)
   ) u_decode (
      .a   (bus.a),
      .sel (sel),
      .hit (hit),
      .idx (idx)
   );

   assign wr_edge  = bus.wr & ~wr_q;
   assign mask_hit = |(sel & RW_MASK);

   // Read source: stored byte for writable registers, owner-supplied byte otherwise.
   assign rd_byte = mask_hit ? io_slice(SLICE_W'(regs),   32'(idx))
                             : io_slice(SLICE_W'(ext_in), 32'(idx));

   always_ff @(posedge clk) begin
      if (!nreset) begin
         regs <= RESET_VAL & RW_BITS;
      end else if (wr_edge) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            if (RW_MASK[i] && sel[i]) begin
               regs[DATA_W*i +: DATA_W] <= bus.d_in;
            end
         end
      end
   end

   // wr_q resets high so a write held across reset release is not taken as an edge.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         wr_q         <= 1'b1;
         wr_pulse     <= '0;
         bus.rd_data  <= 8'hff;
         bus.rd_valid <= 1'b0;
      end else begin
         wr_q     <= bus.wr;
         wr_pulse <= wr_edge ? sel : '0;
         if (bus.rd) begin
            if (hit) begin
               bus.rd_data  <= rd_byte;
               bus.rd_valid <= 1'b1;
            end else begin
               bus.rd_data  <= 8'hff;
               bus.rd_valid <= 1'b0;
            end
         end else begin
            bus.rd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/io_reg_bank.md
Name: io_reg_bank

Overview:
Parametrised successor to the fixed FFxx PPU register decoder. Decodes a contiguous window of NREGS byte registers starting at BASE and provides combinational one-hot selects. It holds the writable registers in flops, generates single-cycle write strobes on write-edge detection, and returns registered read data. Intended for reuse by the PPU, sound and timer register groups.

Parameters:
BASE, 16'hff40, address of register 0.
NREGS, 12, number of registers. Legal range 1..64; BASE+NREGS-1 must be <= 16'hffff.
RW_MASK, {NREGS{1'b1}}, bit i=1 means register i is writable and stored here. Bit i=0 means register i is read-only and sourced from ext_in.
RESET_VAL, {NREGS{8'h00}}, packed NREGS*8 reset values. Slice i is [8*i+7:8*i].

Ports:
clk  input  1  system clock. Everything is on the rising edge.
nreset  input  1  synchronous, active-low reset.
a  input  16  CPU address.
d_in  input  8  CPU write data.
wr  input  1  CPU write request, level; may stay high for several cycles.
rd  input  1  CPU read request, level.
sel  output  NREGS  combinational one-hot select: sel[i] = (a == BASE+i). Independent of wr/rd.
hit  output  1  combinational: |sel.
wr_pulse  output  NREGS  registered one-cycle write strobe per register.
regs  output  NREGS*8  current stored values. Slices for read-only registers read as 8'h00.
ext_in  input  NREGS*8  read data for read-only registers. Writable slices are ignored.
rd_data  output  8  registered read data.
rd_valid  output  1  registered: the rd_data value is from a hit.

Behaviour:
- Decode uses a full 16-bit compare. BASE is not required to be aligned. Addresses outside [BASE, BASE+NREGS-1] give sel = 0 and hit = 0.
- Write edge: internal flop wr_q <= wr. An edge is wr & !wr_q.
- Edge with hit and sel[i], where RW_MASK[i] = 1:
  - at the next clock, regs slice i <= d_in;
  - wr_pulse[i] = 1 for exactly that one cycle.
- Edge with hit and sel[i], where RW_MASK[i] = 0:
  - wr_pulse[i] = 1 for one cycle, so the owner can react (e.g. a DMA or LY-reset trigger);
  - no storage is updated.
- Edge with a miss: no pulse and no update.
- wr held high: only the first cycle counts. A change of address while wr stays high gives no further pulse. Dropping wr for at least one cycle re-arms the edge.
- Read is registered, with 1-cycle latency:
  - rd & hit & sel[i]: at the next clock, rd_data <= (RW_MASK[i] ? regs slice i : ext_in slice i) and rd_valid <= 1.
  - rd & !hit: rd_data <= 8'hff, rd_valid <= 0.
  - !rd: rd_data holds its value, rd_valid <= 0.
- Simultaneous read and write-edge to the same writable register: the read returns the old (pre-write) value. The new value is visible one cycle later.
- Reset (nreset = 0 at a clock edge):
  - regs <= RESET_VAL (writable slices);
  - wr_pulse <= 0, rd_data <= 8'hff, rd_valid <= 0;
  - wr_q <= 1, so a wr held high across reset release does not fire a pulse.
- Reset mid-write: the pending strobe is cancelled and the register takes its RESET_VAL.
- sel and hit remain live during reset, since they are combinational.
- No X on outputs after the first reset edge. Parameter violations are caught with elaboration-time assertions.

Decomposition:
- Shared package io_pkg:
  - localparam widths (ADDR_W = 16, DATA_W = 8);
  - typedef io_byte_t (logic [7:0]);
  - function io_slice(vec, i) for packed-vector slicing;
  - constants for the canonical bases (PPU_BASE 16'hff40, SND_BASE 16'hff10, TIM_BASE 16'hff04).
- One sub-module is natural: io_window_decode. It is purely combinational (a, BASE, NREGS -> sel, hit, and a binary index idx[$clog2(NREGS)-1:0]). Instantiated once; the top level keeps all the flops.

Test Plan:
1. Reset with defaults (BASE ff40, NREGS 12, RESET_VAL all 00) -> regs all 00, rd_data ff, rd_valid 0, wr_pulse 0.
2. a = ff47, d_in = e4, wr high for 4 cycles -> wr_pulse[7] high in exactly 1 cycle, regs slice 7 = e4. A second pulse appears only after wr drops and rises again.
3. RW_MASK bit 4 = 0, ext_in slice 4 = 91, a = ff44, rd = 1 -> next cycle rd_data 91, rd_valid 1. A write to ff44 gives wr_pulse[4] but the read still returns 91.
4. a = ff4c and a = ff3f with rd/wr -> sel 0, hit 0, no pulse, rd_data ff, rd_valid 0.
5. Register 2 = 10; same cycle rd and wr-edge to ff42 with d_in 55 -> rd_data 10. A read one cycle later returns 55.
6. Reparametrise BASE = ff10, NREGS = 23, RESET_VAL slice 0 = 80 -> reset yields regs slice 0 = 80. Writing ff26 pulses wr_pulse[22]; ff27 is a miss. Also: wr held high across nreset release -> no pulse.
